// File: rtl/dmem_wait_responder.sv
// Multi-cycle data-memory responder: req/ack handshake, fixed wait states, big-endian byte RAM.
// Optional build macro DMEM_ADDR_CHECK_EN flags misaligned/out-of-range accesses through err.
module dmem_wait_responder #(
    parameter int BYTE        = 8,
    parameter int DATA_WIDTH  = 32,
    parameter int RAM_DEPTH   = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req,
    input  logic                  we,
    input  logic [31:0]           addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic                  busy,
    output logic                  ack,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  err
);

    localparam int AW = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1;
    localparam logic [3:0] WAIT_LAST = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t                  state_r;
    state_t                  state_s;
    logic [3:0]              cnt_r;
    logic [3:0]              cnt_s;
    logic                    capture_s;
    logic                    access_s;
    logic                    addr_bad_s;
    logic                    write_en_s;
    logic                    cap_we_r;
    logic [31:0]             cap_addr_r;
    logic [DATA_WIDTH-1:0]   cap_wdata_r;
    logic [AW-1:0]           idx0_s;
    logic [AW-1:0]           idx1_s;
    logic [AW-1:0]           idx2_s;
    logic [AW-1:0]           idx3_s;
    logic [DATA_WIDTH-1:0]   load_word_s;

    logic [BYTE-1:0]         mem [RAM_DEPTH];

    // Byte index of (word-aligned address + offset), wrapped onto the RAM depth.
    function automatic logic [AW-1:0] byte_index(input logic [31:0] a, input int unsigned offs);
        logic [31:0] sum;
        logic [31:0] wrapped;
        sum     = {a[31:2], 2'b00} + 32'(offs);
        wrapped = sum % 32'(RAM_DEPTH);
        return wrapped[AW-1:0];
    endfunction

    // Byte lane k of a big-endian word: lane 0 is the most significant byte.
    function automatic logic [BYTE-1:0] be_lane(input logic [DATA_WIDTH-1:0] w, input int unsigned k);
        return w[DATA_WIDTH-1-(k*BYTE) -: BYTE];
    endfunction

    // Byte addresses for the four lanes of the captured request.
    always_comb begin
        idx0_s = byte_index(cap_addr_r, 32'd0);
        idx1_s = byte_index(cap_addr_r, 32'd1);
        idx2_s = byte_index(cap_addr_r, 32'd2);
        idx3_s = byte_index(cap_addr_r, 32'd3);
    end

    // Assemble a big-endian load word from the RAM.
    always_comb begin
        load_word_s = {mem[idx0_s], mem[idx1_s], mem[idx2_s], mem[idx3_s]};
    end

    // Address legality check on the captured request.
    always_comb begin
`ifdef DMEM_ADDR_CHECK_EN
        if ((cap_addr_r[1:0] != 2'b00) || (cap_addr_r > 32'(RAM_DEPTH - 4))) begin
            addr_bad_s = 1'b1;
        end else begin
            addr_bad_s = 1'b0;
        end
`else
        addr_bad_s = 1'b0;
`endif
    end

    // The access happens on the edge that leaves WAIT for RESP.
    always_comb begin
        access_s   = (state_r == S_WAIT) && (cnt_r == WAIT_LAST);
        write_en_s = access_s && cap_we_r && !addr_bad_s && !rst;
    end

    // Next-state logic for the IDLE -> WAIT -> RESP handshake sequence.
    always_comb begin
        state_s   = state_r;
        cnt_s     = cnt_r;
        capture_s = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (req) begin
                    state_s   = S_WAIT;
                    cnt_s     = 4'd0;
                    capture_s = 1'b1;
                end else begin
                    state_s   = S_IDLE;
                end
            end
            S_WAIT: begin
                if (cnt_r == WAIT_LAST) begin
                    state_s = S_RESP;
                end else begin
                    cnt_s   = cnt_r + 4'd1;
                end
            end
            S_RESP: begin
                state_s = S_IDLE;
            end
            default: begin
                state_s = S_IDLE;
                cnt_s   = 4'd0;
            end
        endcase
    end

    // Control state, captured request and registered response outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= S_IDLE;
            cnt_r       <= 4'd0;
            cap_we_r    <= 1'b0;
            cap_addr_r  <= 32'd0;
            cap_wdata_r <= '0;
            busy        <= 1'b0;
            ack         <= 1'b0;
            rdata       <= '0;
            err         <= 1'b0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            busy    <= (state_s != S_IDLE);
            ack     <= (state_s == S_RESP);
            err     <= access_s && addr_bad_s;
            if (capture_s) begin
                cap_we_r    <= we;
                cap_addr_r  <= addr;
                cap_wdata_r <= wdata;
            end
            // Stores leave rdata untouched; a rejected access returns zero.
            if (access_s) begin
                if (addr_bad_s) begin
                    rdata <= '0;
                end else if (!cap_we_r) begin
                    rdata <= load_word_s;
                end
            end
        end
    end

    // Byte RAM write port; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (write_en_s) begin
            mem[idx0_s] <= be_lane(cap_wdata_r, 32'd0);
            mem[idx1_s] <= be_lane(cap_wdata_r, 32'd1);
            mem[idx2_s] <= be_lane(cap_wdata_r, 32'd2);
            mem[idx3_s] <= be_lane(cap_wdata_r, 32'd3);
        end
    end

endmodule

// File: tb/tb_dmem_wait_responder.sv
// Self-checking bench for dmem_wait_responder: vector table, scoreboard queue and corner sequences.
module tb_dmem_wait_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        req, we, busy, ack, err;
    logic [31:0] addr, wdata, rdata;
    logic        req1, we1, busy1, ack1, err1;
    logic [31:0] addr1, wdata1, rdata1;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } resp_t;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    resp_t sb[$];
    vec_t  vecs[7];

    always #5 clk = ~clk;

    dmem_wait_responder #(.WAIT_CYCLES(2)) dut0 (
        .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
        .busy(busy), .ack(ack), .rdata(rdata), .err(err)
    );

    dmem_wait_responder #(.WAIT_CYCLES(0)) dut1 (
        .clk(clk), .rst(rst), .req(req1), .we(we1), .addr(addr1), .wdata(wdata1),
        .busy(busy1), .ack(ack1), .rdata(rdata1), .err(err1)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One transaction on dut0; with mess=1 the inputs are scribbled on while busy.
    task automatic txn(input logic w, input logic [31:0] a, input logic [31:0] d,
                       input logic [31:0] exp_r, input logic exp_e, input bit mess);
        resp_t e;
        resp_t r;
        int    n;
        bit    seen;
        @(negedge clk);
        req = 1'b1; we = w; addr = a; wdata = d;
        @(posedge clk);
        e.rdata = exp_r;
        e.err   = exp_e;
        sb.push_back(e);
        @(negedge clk);
        if (mess) begin
            we = 1'b1; addr = 32'h0000_0040; wdata = 32'hFFFF_FFFF;
        end else begin
            req = 1'b0;
        end
        n = 0;
        seen = 1'b0;
        while (n < 20 && !seen) begin
            if (ack) begin
                seen = 1'b1;
            end else begin
                @(negedge clk);
                n++;
            end
        end
        chk("ack_seen", 32'(seen), 32'd1);
        r = sb.pop_front();
        if (seen) begin
            chk("latency", 32'(n), 32'd3);
            chk("rdata", rdata, r.rdata);
            chk("err", 32'(err), 32'(r.err));
            chk("busy_resp", 32'(busy), 32'd1);
        end
        req = 1'b0;
        @(negedge clk);
        chk("ack_drop", 32'(ack), 32'd0);
        chk("busy_idle", 32'(busy), 32'd0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic exp_busy1 [7];
        logic exp_ack1  [7];

        rst = 1'b1;
        req = 1'b0; we = 1'b0; addr = 32'd0; wdata = 32'd0;
        req1 = 1'b0; we1 = 1'b0; addr1 = 32'd0; wdata1 = 32'd0;
        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ack", 32'(ack), 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        rst = 1'b0;

        vecs[0] = '{1'b1, 32'h20, 32'h1234_5678, 32'h0000_0000, 1'b0};
        vecs[1] = '{1'b0, 32'h20, 32'h0,         32'h1234_5678, 1'b0};
        vecs[2] = '{1'b1, 32'h24, 32'hCAFE_F00D, 32'h1234_5678, 1'b0};
        vecs[3] = '{1'b0, 32'h24, 32'h0,         32'hCAFE_F00D, 1'b0};
        vecs[4] = '{1'b1, 32'hFC, 32'h0102_0304, 32'hCAFE_F00D, 1'b0};
        vecs[5] = '{1'b0, 32'hFC, 32'h0,         32'h0102_0304, 1'b0};
        vecs[6] = '{1'b0, 32'h20, 32'h0,         32'h1234_5678, 1'b0};
        for (int i = 0; i < 7; i++) begin
            txn(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].exp_rdata, vecs[i].exp_err, 1'b0);
        end
        chk("be_byte_20", 32'(dut0.mem[8'h20]), 32'h12);
        chk("be_byte_23", 32'(dut0.mem[8'h23]), 32'h78);

        // Inputs changed while busy must not affect the captured transaction.
        txn(1'b1, 32'h40, 32'h55AA_55AA, 32'h1234_5678, 1'b0, 1'b0);
        txn(1'b1, 32'h30, 32'h0A0B_0C0D, 32'h1234_5678, 1'b0, 1'b1);
        txn(1'b0, 32'h30, 32'h0, 32'h0A0B_0C0D, 1'b0, 1'b0);
        txn(1'b0, 32'h40, 32'h0, 32'h55AA_55AA, 1'b0, 1'b0);

        // Reset in the middle of a store discards it.
        txn(1'b1, 32'h10, 32'h1111_1111, 32'h55AA_55AA, 1'b0, 1'b0);
        @(negedge clk);
        req = 1'b1; we = 1'b1; addr = 32'h10; wdata = 32'hDEAD_BEEF;
        @(posedge clk);
        @(negedge clk);
        req = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_ack", 32'(ack), 32'd0);
        chk("midrst_rdata", rdata, 32'd0);
        chk("midrst_err", 32'(err), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        txn(1'b0, 32'h10, 32'h0, 32'h1111_1111, 1'b0, 1'b0);

`ifdef DMEM_ADDR_CHECK_EN
        txn(1'b1, 32'h22, 32'hBBBB_BBBB, 32'h0000_0000, 1'b1, 1'b0);
        txn(1'b0, 32'h20, 32'h0, 32'h1234_5678, 1'b0, 1'b0);
        txn(1'b0, 32'hFC, 32'h0, 32'h0102_0304, 1'b0, 1'b0);
        txn(1'b0, 32'h100, 32'h0, 32'h0000_0000, 1'b1, 1'b0);
`else
        txn(1'b1, 32'h100, 32'hA1B2_C3D4, 32'h1111_1111, 1'b0, 1'b0);
        txn(1'b0, 32'h0, 32'h0, 32'hA1B2_C3D4, 1'b0, 1'b0);
        txn(1'b0, 32'h22, 32'h0, 32'h1234_5678, 1'b0, 1'b0);
`endif

        // Zero wait states with req held: one IDLE cycle between ack pulses.
        @(negedge clk);
        req1 = 1'b1; we1 = 1'b1; addr1 = 32'h08; wdata1 = 32'h0BAD_F00D;
        @(posedge clk);
        @(negedge clk);
        req1 = 1'b0;
        repeat (3) @(negedge clk);
        exp_busy1 = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        exp_ack1  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        req1 = 1'b1; we1 = 1'b0; addr1 = 32'h08; wdata1 = 32'h0;
        @(posedge clk);
        for (int m = 0; m < 7; m++) begin
            @(negedge clk);
            chk("wc0_busy", 32'(busy1), 32'(exp_busy1[m]));
            chk("wc0_ack", 32'(ack1), 32'(exp_ack1[m]));
            if (exp_ack1[m]) begin
                chk("wc0_rdata", rdata1, 32'h0BAD_F00D);
                chk("wc0_err", 32'(err1), 32'd0);
            end
        end
        req1 = 1'b0;
        repeat (3) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dmem_wait_responder.md
Name: dmem_wait_responder

Overview:
- Responder side of the data-memory interface for a multi-cycle memory system.
- The MEM stage of a stall-capable core issues word load/store requests. This block accepts each request with a req/ack handshake, inserts a fixed number of wait states, then accesses a byte-organised big-endian RAM and returns read data with a one-cycle ack.
- Replaces the zero-latency data RAM when the memory is not single-cycle.

Parameters:
- BYTE, 8, bits per RAM entry.
- DATA_WIDTH, 32, request/response data width; fixed at 4*BYTE.
- RAM_DEPTH, 256, number of byte entries in the internal RAM.
- WAIT_CYCLES, 2, wait states inserted between accept and response; legal range 0..15.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous active-high reset.
- req  in  1  request valid; sampled only in IDLE.
- we  in  1  1 = store, 0 = load; captured with req.
- addr  in  32  byte address; captured with req.
- wdata  in  32  store data; captured with req.
- busy  out  1  high while a request is in flight, i.e. state != IDLE.
- ack  out  1  one-cycle response strobe.
- rdata  out  32  load data; valid while ack=1.
- err  out  1  error flag; valid while ack=1. Constant 0 unless the optional feature is compiled in.

Behaviour:
- Reset (asynchronous, any state): state=IDLE, wait counter=0, busy=0, ack=0, rdata=0, err=0, captured request registers=0.
  - RAM contents are not reset.
  - An in-flight store is discarded; no RAM write occurs.
- States: IDLE, WAIT, RESP. busy = (state != IDLE); ack = (state == RESP), registered.
- IDLE:
  - On an edge with req=1: capture we/addr/wdata, clear cnt to 0, go to WAIT.
  - On an edge with req=0: stay in IDLE.
- WAIT:
  - If cnt == WAIT_CYCLES: perform the access on this edge, go to RESP.
  - Otherwise: cnt <= cnt+1 and stay in WAIT.
  - cnt is 4 bits.
- Access, on the edge entering RESP:
  - Index i = captured addr with bits [1:0] forced to 0, taken modulo RAM_DEPTH. Index wraps: address RAM_DEPTH maps to entry 0.
  - Store: RAM[i]=wdata[31:24], RAM[i+1]=wdata[23:16], RAM[i+2]=wdata[15:8], RAM[i+3]=wdata[7:0]. Each byte index is also taken modulo RAM_DEPTH. rdata is left unchanged.
  - Load: rdata <= {RAM[i],RAM[i+1],RAM[i+2],RAM[i+3]}.
- RESP: lasts exactly one cycle, then unconditionally returns to IDLE.
- Latency: req accepted at edge k gives ack=1 during the cycle following edge k+WAIT_CYCLES+1.
  - WAIT_CYCLES=0: ack appears one cycle after acceptance.
- Throughput: at least one IDLE cycle between consecutive ack pulses. A held req is accepted again in that IDLE cycle.
- req, we, addr and wdata are ignored while busy=1. The captured values are used for the whole transaction.
- rdata holds its last value outside RESP.
- Load following a store to the same address returns the stored word.

Optional Feature:
- Macro: DMEM_ADDR_CHECK_EN.
- With the macro, an error is flagged when addr[1:0] != 0 or addr > RAM_DEPTH-4 (captured value). In that case:
  - the access is suppressed: no RAM write, rdata <= 0;
  - err=1 during the RESP cycle; otherwise err=0 in RESP.
  - Timing and ack are unchanged.
- Without the macro: err is tied to 0; low address bits are ignored; the index wraps as described above.

Test Plan:
- Reset: assert rst mid-WAIT with we=1, addr=0x10, wdata=0xDEADBEEF -> busy/ack/rdata/err go to 0 immediately; a later load of 0x10 does not return 0xDEADBEEF.
- WAIT_CYCLES=2: store 0x12345678 to 0x20 at edge k -> ack high exactly during the cycle after edge k+3. Then load 0x20 -> rdata=0x12345678 with ack, and byte 0x20 holds 0x12 (big-endian).
- WAIT_CYCLES=0: req held high for two loads -> ack pulses separated by exactly one IDLE cycle; busy low only in that cycle.
- Ignored request: while busy=1, change addr to 0x40 and wdata to 0xFFFFFFFF -> the captured transaction completes using the original addr/wdata; 0x40 is unchanged.
- Wrap, feature off: store 0xA1B2C3D4 to addr=RAM_DEPTH (256) -> load of addr 0 returns 0xA1B2C3D4, err=0.
- DMEM_ADDR_CHECK_EN: store to addr=0x22 -> ack with err=1 and no RAM change. Load from addr=0xFC -> err=0. Load from addr=0x100 -> err=1, rdata=0.
